// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// encodings and the legality check on the access size field.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_REQ1,
    ST_LAST,
    ST_RESP
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Stores only look at [1:0], so 100/101 fold onto B/H; that makes the
  // illegal set identical for loads and stores.
  function automatic logic lsu_illegal(input logic [2:0] funct3);
    lsu_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, split detection, write-data lane
// shifting and read-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rdata64,
  output logic [7:0]  o_mask,
  output logic        o_split,
  output logic [63:0] o_wdataShifted,
  output logic [31:0] o_rdataExt
);

  logic [7:0]  w_sizeMask;
  logic [31:0] w_rdataLow;
  logic        w_signed;

  always_comb begin
    w_sizeMask = 8'h00;
    case (i_funct3[1:0])
      2'b00:   w_sizeMask = 8'h01;
      2'b01:   w_sizeMask = 8'h03;
      2'b10:   w_sizeMask = 8'h0F;
      default: w_sizeMask = 8'h00;
    endcase
  end

  assign o_mask         = w_sizeMask << i_offset;
  assign o_split        = |o_mask[7:4];
  assign o_wdataShifted = {32'b0, i_wdata} << {i_offset, 3'b000};
  assign w_rdataLow     = 32'(i_rdata64 >> {i_offset, 3'b000});
  assign w_signed       = ~i_funct3[2];

  always_comb begin
    o_rdataExt = w_rdataLow;
    case (i_funct3[1:0])
      2'b00:   o_rdataExt = {{24{w_signed & w_rdataLow[7]}}, w_rdataLow[7:0]};
      2'b01:   o_rdataExt = {{16{w_signed & w_rdataLow[15]}}, w_rdataLow[15:0]};
      default: o_rdataExt = w_rdataLow;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte-addressed request into one or two word
// accesses, then returns the extended load data with a one-cycle pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-3:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  lsu_state_t              r_state;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    r_rspValid;
  logic                    r_rspErr;
  logic [DATA_WIDTH-1:0]   r_rspRdata;
  logic                    r_memReq;
  logic                    r_memWe;
  logic [DATA_WIDTH-3:0]   r_memAddr;
  logic [DATA_WIDTH/8-1:0] r_memBe;
  logic [DATA_WIDTH-1:0]   r_memWdata;

  logic                    w_idle;
  logic                    w_accept;
  logic [2:0]              w_funct3;
  logic [1:0]              w_offset;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [2*DATA_WIDTH-1:0] w_rdata64;
  logic [7:0]              w_mask;
  logic                    w_split;
  logic [2*DATA_WIDTH-1:0] w_wdataShifted;
  logic [DATA_WIDTH-1:0]   w_rdataExt;

  // In IDLE the aligner sees the incoming request so the first access can be
  // registered on the accept edge; afterwards it sees the latched fields.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = req_valid && w_idle;
  assign w_funct3  = w_idle ? req_funct3     : r_funct3;
  assign w_offset  = w_idle ? req_addr[1:0]  : r_addr[1:0];
  assign w_wdata   = w_idle ? req_wdata      : r_wdata;
  assign w_rdata64 = w_split ? {mem_rdata, r_lo} : {{DATA_WIDTH{1'b0}}, mem_rdata};

  lsu_align u_align (
    .i_funct3       (w_funct3),
    .i_offset       (w_offset),
    .i_wdata        (w_wdata),
    .i_rdata64      (w_rdata64),
    .o_mask         (w_mask),
    .o_split        (w_split),
    .o_wdataShifted (w_wdataShifted),
    .o_rdataExt     (w_rdataExt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lo       <= '0;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memBe    <= '0;
      r_memWdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (lsu_illegal(req_funct3)) begin
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspRdata <= '0;
              r_state    <= ST_RESP;
            end else begin
              r_memReq   <= 1'b1;
              r_memWe    <= req_we;
              r_memAddr  <= req_addr[DATA_WIDTH-1:2];
              r_memBe    <= w_mask[3:0];
              r_memWdata <= w_wdataShifted[DATA_WIDTH-1:0];
              r_state    <= ST_REQ0;
            end
          end
        end
        ST_REQ0: begin
          if (w_split) begin
            r_memAddr  <= r_addr[DATA_WIDTH-1:2] + (DATA_WIDTH-2)'(1);
            r_memBe    <= w_mask[7:4];
            r_memWdata <= w_wdataShifted[2*DATA_WIDTH-1:DATA_WIDTH];
            r_state    <= ST_REQ1;
          end else begin
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
            r_memBe  <= '0;
            r_state  <= ST_LAST;
          end
        end
        ST_REQ1: begin
          r_lo     <= mem_rdata;
          r_memReq <= 1'b0;
          r_memWe  <= 1'b0;
          r_memBe  <= '0;
          r_state  <= ST_LAST;
        end
        ST_LAST: begin
          r_rspValid <= 1'b1;
          r_rspErr   <= 1'b0;
          r_rspRdata <= r_we ? '0 : w_rdataExt;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_rspValid <= 1'b0;
          r_rspErr   <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign rsp_valid = r_rspValid;
  assign rsp_err   = r_rspErr;
  assign rsp_rdata = r_rspRdata;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_be    = r_memBe;
  assign mem_wdata = r_memWdata;

endmodule
